regfile_2w3r: RTL

Parametrised successor to the single-write, dual-read RegisterFile used by the CPU datapath.
- Read: three combinational read ports (A, B, C).
- Write: two synchronous write ports with fixed priority.
- Optional write-to-read bypass and optional hardwired zero register.
- Sequenced clear: a Clr pulse zeroes one register per cycle without a reset, so the pipeline can flush architectural state cheaply.

---
 rtl/regfile_2w3r.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_2w3r.sv
// Three-read, two-write register file with optional bypass and hardwired zero.
// A Clr pulse starts a sweep that zeroes one register per cycle while Busy is high.
module regfile_2w3r #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic [WIDTH-1:0]  BusA,
  output logic [WIDTH-1:0]  BusB,
  output logic [WIDTH-1:0]  BusC,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [WIDTH-1:0]  BusW0,
  input  logic              RegWr0,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [WIDTH-1:0]  BusW1,
  input  logic              RegWr1,
  input  logic              Clr,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    regs_q [DEPTH];

  logic zero_en;
  logic byp_en;
  logic wr0_en, wr1_en, wr0_keep;

  assign zero_en = (ZERO_REG != 0);
  assign byp_en  = (BYPASS != 0);

  // Writes only land in IDLE; address 0 is dropped when it is hardwired.
  assign wr0_en   = RegWr0 && (state_q == IDLE) && !(zero_en && (RW0 == '0));
  assign wr1_en   = RegWr1 && (state_q == IDLE) && !(zero_en && (RW1 == '0));
  assign wr0_keep = wr0_en && !(wr1_en && (RW1 == RW0));

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = regs_q[addr];
    if (byp_en) begin
      if (wr0_en && (RW0 == addr)) data = BusW0;
      if (wr1_en && (RW1 == addr)) data = BusW1;
    end
    if (zero_en && (addr == '0)) data = '0;
    return data;
  endfunction

  assign BusA = read_port(RA);
  assign BusB = read_port(RB);
  assign BusC = read_port(RC);
  assign Busy = busy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          state_d = SWEEP;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // The sweep owns the array exclusively; port 1 wins a same-address collision.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      regs_q[ptr_q] <= '0;
    end else begin
      if (wr0_keep) regs_q[RW0] <= BusW0;
      if (wr1_en)   regs_q[RW1] <= BusW1;
    end
  end

endmodule
